inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_if.sv | 30 +++
 rtl/inst_fetch_queue.sv | 114 +++++++++++
 tb/tb_inst_fetch_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch push side, decode pop side, redirect control.
// Ports: ce/if_pc/if_inst/if_valid/if_ready (fetch), flush/stall (control),
//        id_pc/id_inst/id_valid (decode), count (occupancy, CNT_W bits).
interface inst_fetch_queue_if #(
  parameter int CNT_W = 3
);
  logic             ce;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_valid;
  logic             if_ready;
  logic             flush;
  logic             stall;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic             id_valid;
  logic [CNT_W-1:0] count;

  // master: the fetch/decode pipeline around the queue
  modport master (
    output ce, if_pc, if_inst, if_valid, flush, stall,
    input  if_ready, id_pc, id_inst, id_valid, count
  );

  // slave: the queue itself
  modport slave (
    input  ce, if_pc, if_inst, if_valid, flush, stall,
    output if_ready, id_pc, id_inst, id_valid, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, inst} between fetch and decode.
// Latency: 1 cycle push-to-head; with IFQ_BYPASS_EN defined, an empty queue
// with decode ready forwards the fetch combinationally (0 cycles, not stored).
// Backpressure: if_ready drops when full (independent of a same-cycle pop);
// stall holds the head; flush empties the queue on the next edge.
// Ports: clk (rising edge), rst (async, active-low), bus (inst_fetch_queue_if.slave).
// Parameters: DEPTH (power of 2, 2..16), CNT_W (= log2(DEPTH)+1).
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_fetch_queue_if.slave        bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;
  logic id_valid;
  logic store;
  logic consume;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Ready looks only at occupancy so fetch never waits on the decode-side stall path.
  assign bus.if_ready = !full;

  assign push = bus.if_valid & !full & bus.ce & !bus.flush;

`ifdef IFQ_BYPASS_EN
  // Empty queue and decode ready: hand the fetch straight through.
  assign bypass = empty & push & !bus.stall;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = !empty | bypass;
  assign pop      = id_valid & !bus.stall & !bus.flush;

  // A bypassed fetch is both pushed and popped in the same cycle but never touches storage.
  assign store   = push & !bypass;
  assign consume = pop & !bypass;

  assign bus.id_valid = id_valid;
  assign bus.count    = count_q;

  always_comb begin
    bus.id_pc   = 32'h0000_0000;
    bus.id_inst = 32'h0000_0000;
    if (bypass) begin
      bus.id_pc   = bus.if_pc;
      bus.id_inst = bus.if_inst;
    end else if (!empty) begin
      bus.id_pc   = pc_mem[rd_ptr];
      bus.id_inst = inst_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= 32'h0000_0000;
        inst_mem[i] <= 32'h0000_0000;
      end
    end else if (bus.flush) begin
      // Redirect wins over everything; stale storage is harmless once count is 0.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) begin
        pc_mem[wr_ptr]   <= bus.if_pc;
        inst_mem[wr_ptr] <= bus.if_inst;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (consume) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({store, consume})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Occupancy can never exceed the number of entries.
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CNT_W'(DEPTH));

  // Pointer distance must agree with occupancy (modulo DEPTH).
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(wr_ptr - rd_ptr) == PTR_W'(count_q));

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk;
  logic rst;
  inst_fetch_queue_if #(.CNT_W(CNT_W)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ent_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, compare at the falling edge
  // against the scoreboard, then advance the scoreboard to model the next edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic st, input logic fl, input logic c);
    int   sz;
    logic byp;
    logic exp_vld;
    logic push;
    logic pop;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.stall    = st;
    bus.flush    = fl;
    bus.ce       = c;
    @(negedge clk);
    sz      = exp_q.size();
    byp     = BYP && (sz == 0) && v && c && !fl && !st;
    exp_vld = (sz != 0) || byp;
    exp_pc   = 32'h0;
    exp_inst = 32'h0;
    if (byp) begin
      exp_pc   = pc;
      exp_inst = inst;
    end else if (sz != 0) begin
      exp_pc   = exp_q[0].pc;
      exp_inst = exp_q[0].inst;
    end
    check_eq("count",    32'(bus.count), 32'(sz));
    check_eq("if_ready", 32'(bus.if_ready), 32'(sz != DEPTH));
    check_eq("id_valid", 32'(bus.id_valid), 32'(exp_vld));
    check_eq("id_pc",    bus.id_pc, exp_pc);
    check_eq("id_inst",  bus.id_inst, exp_inst);
    push = v && (sz != DEPTH) && c && !fl;
    pop  = exp_vld && !st && !fl;
    if (fl) begin
      exp_q.delete();
    end else if (!byp) begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back('{pc: pc, inst: inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 32'h0, 32'h0, st, 1'b0, 1'b1);
  endtask

  initial begin
    rst          = 1'b0;
    bus.ce       = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = 32'h0;
    bus.if_inst  = 32'h0;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;

    // Reset state, observed before any clock edge
    phase = "reset";
    #3;
    check_eq("count",    32'(bus.count), 32'd0);
    check_eq("id_valid", 32'(bus.id_valid), 32'd0);
    check_eq("if_ready", 32'(bus.if_ready), 32'd1);
    check_eq("id_pc",    bus.id_pc, 32'h0);
    check_eq("id_inst",  bus.id_inst, 32'h0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full under stall, then a rejected fifth push
    phase = "fill";
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h10, 32'hA4, 1'b1, 1'b0, 1'b1);
    check_eq("full_count", 32'(bus.count), 32'd4);

    // Drain in order, then empty outputs read as NOP
    phase = "drain";
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Steady push+pop at count=2 across pointer wraps
    phase = "stream";
    step(1'b1, 32'h40, 32'hB0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h44, 32'hB1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h48 + 32'(4 * i), 32'hB2 + 32'(i), 1'b0, 1'b0, 1'b1);
    check_eq("stream_count", 32'(bus.count), 32'd2);

    // Flush beats a concurrent push with stall at count=3
    phase = "flush";
    step(1'b1, 32'h80, 32'hC0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h200, 32'hC1, 1'b1, 1'b1, 1'b1);
    check_eq("flush_count", 32'(bus.count), 32'd0);
    check_eq("flush_vld",   32'(bus.id_valid), 32'd0);
    idle(1'b0);

    // ce low blocks pushes and keeps contents
    phase = "ce_off";
    step(1'b1, 32'h300, 32'hD0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h304, 32'hD1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h308, 32'hD2, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Asynchronous reset mid-cycle with two entries queued
    phase = "async_rst";
    step(1'b1, 32'h400, 32'hE0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h404, 32'hE1, 1'b1, 1'b0, 1'b1);
    bus.if_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("count",    32'(bus.count), 32'd0);
    check_eq("id_valid", 32'(bus.id_valid), 32'd0);
    check_eq("if_ready", 32'(bus.if_ready), 32'd1);
    check_eq("id_pc",    bus.id_pc, 32'h0);
    check_eq("id_inst",  bus.id_inst, 32'h0);
    exp_q.delete();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Push into an empty queue with decode ready (bypass or 1-cycle latency)
    phase = "empty_push";
    step(1'b1, 32'h100, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Mixed random traffic
    phase = "random";
    for (int i = 0; i < 120; i++)
      step($urandom_range(0, 3) != 0, 32'h1000 + 32'(4 * i), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) != 0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
